pixel_store_param: RTL
======================

Name: pixel_store_param

Overview:
- Parametrised frame-buffer store for the paint pipeline.
- One synchronous pixel write port (brush) and one registered read port (display scan), with configurable canvas size and colour depth.
- Built-in clear engine sweeps the whole canvas to a chosen colour, either on request or automatically after reset.
- Sits between the brush/cursor logic (write side) and the VGA colour lookup (read side).

Parameters:
- WIDTH, 200, canvas columns (x range 0..WIDTH-1).
- HEIGHT, 200, canvas rows (y range 0..HEIGHT-1).
- CW, 3, colour-code width in bits.
- RXW, 10, width of the read coordinate ports rx/ry (VGA counter width).
- WXW, 8, width of the write coordinate ports wx/wy.
- OOB_COLOR, 0, colour returned for reads outside the canvas.
- CLEAR_ON_RESET, 1, when 1 the canvas is cleared to RESET_COLOR after reset.
- RESET_COLOR, 0, fill colour used by the reset-triggered clear.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- brush  input  1  write enable for the pixel at (wx, wy).
- wx  input  WXW  write column.
- wy  input  WXW  write row.
- new_color  input  CW  colour to write.
- rx  input  RXW  read column.
- ry  input  RXW  read row.
- clear_req  input  1  single-cycle request to fill the canvas with clear_color.
- clear_color  input  CW  fill colour; sampled only when clear_req is accepted.
- color_code  output  CW  registered read data.
- busy  output  1  high while the clear engine runs.
- clear_done  output  1  one-cycle pulse after the last clear write.

Behaviour:
- Storage: WIDTH*HEIGHT entries of CW bits, linear address y*WIDTH+x. The array itself is not reset; only the clear engine initialises it.
- Reset (reset_n low, asynchronous):
  - color_code=0, clear_done=0, clear counter=0.
  - If CLEAR_ON_RESET=1: state=CLEAR, fill colour=RESET_COLOR, busy=1.
  - Otherwise: state=IDLE, busy=0.
- Read path:
  - rx/ry sampled at edge k; color_code valid after edge k (1-cycle latency).
  - rx>=WIDTH or ry>=HEIGHT (full RXW compare, no truncation) returns OOB_COLOR.
  - Read and write to the same address in the same cycle returns the OLD data (read-first).
  - Reads stay active in every state, including CLEAR; partially cleared contents are visible.
- Write path, IDLE only:
  - brush=1 with wx<WIDTH and wy<HEIGHT writes new_color at that edge.
  - Out-of-range writes are silently dropped.
- FSM states IDLE and CLEAR:
  - IDLE, clear_req=1: latch clear_color, counter=0, go to CLEAR; busy=1 from the next cycle. A brush write in the same cycle is still performed; the clear later overwrites it.
  - CLEAR: one write per cycle, mem[counter]<=fill colour, counter+1.
  - When counter==WIDTH*HEIGHT-1: perform that write, go to IDLE, busy=0 and clear_done=1 for exactly one cycle on the next cycle.
  - A full clear takes WIDTH*HEIGHT cycles.
  - In CLEAR, brush and clear_req are ignored (dropped, not queued).
- Reset asserted mid-clear aborts the sweep. With CLEAR_ON_RESET=1 the sweep restarts from address 0 with RESET_COLOR.
- Counter width is $clog2(WIDTH*HEIGHT). Address arithmetic must not wrap for the maximum x and y.

Test Plan:
- Configuration WIDTH=8, HEIGHT=4, CW=3, CLEAR_ON_RESET=1, RESET_COLOR=5.
- Reset release -> busy=1 for exactly 32 cycles, clear_done pulses once, then every in-range read returns 5.
- Write brush=1, (wx,wy)=(7,3), new_color=2; next cycle read (7,3) -> color_code=2 one cycle after the address is applied. Read (8,0) and (0,4) -> OOB_COLOR=0.
- Same-cycle write (2,1)=6 and read (2,1) -> old value 5; the following read of (2,1) returns 6.
- In IDLE, clear_req=1 with clear_color=3 together with brush writing (0,0)=1 -> 32 busy cycles, all reads then return 3 including (0,0). brush and clear_req pulses issued during busy have no effect.
- Assert reset_n low at sweep address 10 during a clear_color=3 sweep -> outputs reset immediately. After release, a fresh 32-cycle sweep runs and all pixels read 5.
- CLEAR_ON_RESET=0 build -> busy=0 immediately after reset, and writes and reads work from the first cycle.

Source files
------------

// File: rtl/pixel_store_param.sv
// Parametrised frame-buffer store: one brush write port, one registered display read port,
// and a clear engine that sweeps the canvas to a fill colour on request or after reset.
module pixel_store_param #(
   parameter int unsigned WIDTH          = 200,
   parameter int unsigned HEIGHT         = 200,
   parameter int unsigned CW             = 3,
   parameter int unsigned RXW            = 10,
   parameter int unsigned WXW            = 8,
   parameter int unsigned OOB_COLOR      = 0,
   parameter int unsigned CLEAR_ON_RESET = 1,
   parameter int unsigned RESET_COLOR    = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           brush,
   input  logic [WXW-1:0] wx,
   input  logic [WXW-1:0] wy,
   input  logic [CW-1:0]  new_color,
   input  logic [RXW-1:0] rx,
   input  logic [RXW-1:0] ry,
   input  logic           clear_req,
   input  logic [CW-1:0]  clear_color,
   output logic [CW-1:0]  color_code,
   output logic           busy,
   output logic           clear_done
);

   localparam int unsigned DEPTH = WIDTH * HEIGHT;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  fill_q, fill_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [CW-1:0]  color_q;

   logic [CW-1:0]  mem_q [DEPTH];
   logic           mem_we_s;
   logic [AW-1:0]  mem_waddr_s;
   logic [CW-1:0]  mem_wdata_s;

   logic           w_in_range_s;
   logic           r_in_range_s;
   logic [AW-1:0]  waddr_s;
   logic [AW-1:0]  raddr_s;

   // Range checks use the full port width; address math is only used once in range.
   assign w_in_range_s = (32'(wx) < WIDTH) && (32'(wy) < HEIGHT);
   assign r_in_range_s = (32'(rx) < WIDTH) && (32'(ry) < HEIGHT);
   assign waddr_s      = AW'(wy) * AW'(WIDTH) + AW'(wx);
   assign raddr_s      = AW'(ry) * AW'(WIDTH) + AW'(rx);

   // State, sweep counter, fill colour and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         cnt_q   <= AW'(0);
         fill_q  <= CW'(RESET_COLOR);
         busy_q  <= (CLEAR_ON_RESET != 0);
         done_q  <= 1'b0;
         color_q <= CW'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         color_q <= r_in_range_s ? mem_q[raddr_s] : CW'(OOB_COLOR);
      end
   end

   // Next-state logic: accept a clear in IDLE, walk the canvas one address per cycle in CLEAR.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               cnt_d   = AW'(0);
               fill_d  = clear_color;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = AW'(0);
            end else begin
               cnt_d   = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = AW'(0);
         end
      endcase
   end

   // Output logic: flag next values and the single memory write-port mux.
   always_comb begin
      busy_d      = (state_d == ST_CLEAR);
      done_d      = 1'b0;
      mem_we_s    = 1'b0;
      mem_waddr_s = waddr_s;
      mem_wdata_s = new_color;
      case (state_q)
         ST_IDLE: begin
            if (brush && w_in_range_s) begin
               mem_we_s = 1'b1;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         ST_CLEAR: begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_q;
            mem_wdata_s = fill_q;
            done_d      = (cnt_q == LAST_ADDR);
         end
         default: begin
            mem_we_s = 1'b0;
         end
      endcase
   end

   // Pixel array: deliberately not reset, the clear engine initialises it.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign color_code = color_q;
   assign busy       = busy_q;
   assign clear_done = done_q;

endmodule
